// File: rtl/bft_pkt_pkg.sv
// Shared framing constants and FSM encoding for the packet reader.
package bft_pkt_pkg;
  localparam int DSIZE_DEF = 32;
  localparam int LEN_W_DEF = 8;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } state_t;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry output buffer: push/pop in the same cycle, oldest entry presented.
module skid_buf2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_cnt
);
  logic [1:0][W-1:0] r_mem;
  logic              r_wr;
  logic              r_rd;
  logic [1:0]        r_cnt;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = (r_cnt != 2'd0) && i_ready;
  assign w_push = i_valid && (r_cnt != 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_mem[r_rd];
  assign o_cnt   = r_cnt;
endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains a show-ahead FIFO, frames header+L payload words, marks the last word.
module fifo_pkt_reader
  import bft_pkt_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             pkt_done,
  output logic             busy
);
  state_t           r_state;
  logic [LEN_W-1:0] r_rem;
  logic [LEN_W-1:0] w_len;
  logic [1:0]       w_cnt;
  logic             w_pop;
  logic             w_last;
  logic [DSIZE:0]   w_bdata;

  assign w_len = rdata[LEN_W-1:0];
  // Occupancy is sampled before this cycle's drain, so a full buffer resumes next cycle.
  assign w_pop = rst_n && !rempty && (w_cnt < 2'd2);
  assign rinc  = w_pop;

  always_comb begin
    w_last = 1'b0;
    if (r_state == ST_HDR) w_last = (w_len == '0);
    else                   w_last = (r_rem == LEN_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HDR;
      r_rem   <= '0;
    end else if (w_pop) begin
      case (r_state)
        ST_HDR: begin
          r_rem   <= w_len;
          r_state <= (w_len == '0) ? ST_HDR : ST_BODY;
        end
        ST_BODY: begin
          r_rem <= r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) r_state <= ST_HDR;
        end
        default: r_state <= ST_HDR;
      endcase
    end
  end

  skid_buf2 #(.W(DSIZE + 1)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_pop),
    .i_data  ({w_last, rdata}),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (w_bdata),
    .o_cnt   (w_cnt)
  );

  assign out_data = w_bdata[DSIZE-1:0];
  assign out_last = w_bdata[DSIZE];
  assign pkt_done = out_valid && out_ready && out_last;
  assign busy     = (r_state == ST_BODY) || (w_cnt != 2'd0);
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench: FIFO model feeds the reader, negedge monitor logs the stream.
module tb_fifo_pkt_reader;
  logic        clk;
  logic        rst_n;
  logic [31:0] rdata;
  logic        rempty;
  logic        rinc;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        pkt_done;
  logic        busy;

  fifo_pkt_reader #(.DSIZE(32), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .pkt_done(pkt_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int err = 0;

  // FIFO model (show-ahead), flushed by the shared reset
  logic [31:0] fmem [0:511];
  int wr_i = 0;
  int rd_i = 0;
  int pop_n = 0;
  int bad_pop = 0;
  int cyc = 0;

  assign rempty = (rd_i == wr_i);
  assign rdata  = fmem[rd_i[8:0]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_i <= wr_i;
    else begin
      cyc <= cyc + 1;
      if (rinc) begin
        if (rd_i == wr_i) bad_pop <= bad_pop + 1;
        else begin
          rd_i  <= rd_i + 1;
          pop_n <= pop_n + 1;
        end
      end
    end
  end

  // Stream monitor: a word transfers at the posedge following this negedge
  logic [31:0] obs_d [0:511];
  logic        obs_l [0:511];
  int          obs_c [0:511];
  int obs_n = 0;
  int done_n = 0;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      obs_d[obs_n[8:0]] <= out_data;
      obs_l[obs_n[8:0]] <= out_last;
      obs_c[obs_n[8:0]] <= cyc;
      obs_n <= obs_n + 1;
    end
    if (pkt_done) done_n <= done_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fmem[wr_i[8:0]] = w;
    wr_i++;
  endtask

  task automatic wait_outs(input int base, input int n, input int budget, output bit ok);
    int k = 0;
    while ((obs_n - base) < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = ((obs_n - base) >= n);
  endtask

  task automatic test_reset();
    cmp++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    cmp++; if (out_last !== 1'b0) begin err++; $display("FAIL reset_last got=%b want=0", out_last); end
    cmp++; if (pkt_done !== 1'b0) begin err++; $display("FAIL reset_done got=%b want=0", pkt_done); end
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL reset_busy got=%b want=0", busy); end
    cmp++; if (out_data !== 32'h0) begin err++; $display("FAIL reset_data got=%h want=0", out_data); end
    cmp++; if (rinc !== 1'b0) begin err++; $display("FAIL reset_rinc got=%b want=0", rinc); end
  endtask

  task automatic test_basic();
    int b, d;
    bit ok;
    logic [31:0] exp [4];
    exp = '{32'h0000_0003, 32'hA1, 32'hA2, 32'hA3};
    b = obs_n; d = done_n;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(exp[i]);
    wait_outs(b, 4, 30, ok);
    cmp++; if (!ok) begin err++; $display("FAIL basic_count got=%0d want=4", obs_n - b); end
    for (int i = 0; i < 4; i++) begin
      cmp++;
      if (obs_d[b+i] !== exp[i] || obs_l[b+i] !== (i == 3)) begin
        err++; $display("FAIL basic_word%0d got=%h/%b want=%h/%b", i, obs_d[b+i], obs_l[b+i], exp[i], i == 3);
      end
    end
    cmp++; if (obs_c[b+3] - obs_c[b] !== 3) begin err++; $display("FAIL basic_consec got=%0d want=3", obs_c[b+3] - obs_c[b]); end
    cmp++; if (done_n - d !== 1) begin err++; $display("FAIL basic_done got=%0d want=1", done_n - d); end
  endtask

  task automatic test_zero_len();
    int b, d;
    bit ok;
    logic [31:0] exp [3];
    logic        el  [3];
    // High header bits must not affect framing: 0x100 still means L=0
    exp = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00BB};
    el  = '{1'b1, 1'b0, 1'b1};
    b = obs_n; d = done_n;
    for (int i = 0; i < 3; i++) push(exp[i]);
    wait_outs(b, 3, 30, ok);
    cmp++; if (!ok) begin err++; $display("FAIL zlen_count got=%0d want=3", obs_n - b); end
    for (int i = 0; i < 3; i++) begin
      cmp++;
      if (obs_d[b+i] !== exp[i] || obs_l[b+i] !== el[i]) begin
        err++; $display("FAIL zlen_word%0d got=%h/%b want=%h/%b", i, obs_d[b+i], obs_l[b+i], exp[i], el[i]);
      end
    end
    cmp++; if (done_n - d !== 2) begin err++; $display("FAIL zlen_done got=%0d want=2", done_n - d); end
  endtask

  task automatic test_backpressure();
    int b, p, d;
    bit ok;
    logic [31:0] held;
    b = obs_n; p = pop_n; d = done_n;
    out_ready = 1'b0;
    push(32'h0000_0009);
    for (int i = 1; i < 10; i++) push(32'hC0 + i);
    tick(5);
    cmp++; if (pop_n - p !== 2) begin err++; $display("FAIL bp_pops got=%0d want=2", pop_n - p); end
    cmp++; if (rinc !== 1'b0) begin err++; $display("FAIL bp_rinc got=%b want=0", rinc); end
    cmp++; if (busy !== 1'b1) begin err++; $display("FAIL bp_busy got=%b want=1", busy); end
    held = out_data;
    tick(2);
    cmp++; if (out_data !== 32'h0000_0009 || held !== 32'h0000_0009) begin
      err++; $display("FAIL bp_hold got=%h,%h want=00000009", held, out_data);
    end
    out_ready = 1'b1;
    wait_outs(b, 10, 40, ok);
    cmp++; if (!ok) begin err++; $display("FAIL bp_count got=%0d want=10", obs_n - b); end
    for (int i = 0; i < 10; i++) begin
      cmp++;
      if (obs_d[b+i] !== ((i == 0) ? 32'h9 : 32'hC0 + i) || obs_l[b+i] !== (i == 9)) begin
        err++; $display("FAIL bp_word%0d got=%h/%b", i, obs_d[b+i], obs_l[b+i]);
      end
    end
    cmp++; if (done_n - d !== 1) begin err++; $display("FAIL bp_done got=%0d want=1", done_n - d); end
  endtask

  task automatic test_empty();
    for (int i = 0; i < 5; i++) begin
      cmp++;
      if (rinc !== 1'b0 || out_valid !== 1'b0) begin
        err++; $display("FAIL empty_idle%0d rinc=%b valid=%b want 0/0", i, rinc, out_valid);
      end
      tick(1);
    end
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    cmp++; if (busy !== 1'b0) begin err++; $display("FAIL empty_busy got=%b want=0", busy); end
    cmp++; if (bad_pop !== 0) begin err++; $display("FAIL empty_pop got=%0d want=0", bad_pop); end
  endtask

  task automatic test_reset_mid();
    int b, p, d, k;
    bit ok;
    p = pop_n;
    push(32'h0000_0005); push(32'hD1); push(32'hD2);
    k = 0;
    while (pop_n - p < 3 && k < 20) begin tick(1); k++; end
    cmp++; if (pop_n - p !== 3) begin err++; $display("FAIL rmid_pops got=%0d want=3", pop_n - p); end
    rst_n = 1'b0;
    #1;
    cmp++; if ({out_valid, out_last, pkt_done, busy, rinc} !== 5'b0 || out_data !== 32'h0) begin
      err++; $display("FAIL rmid_async got=%b%b%b%b%b/%h want=0", out_valid, out_last, pkt_done, busy, rinc, out_data);
    end
    tick(1);
    rst_n = 1'b1;
    b = obs_n; d = done_n;
    push(32'h0000_0002); push(32'h11); push(32'h22);
    wait_outs(b, 3, 30, ok);
    cmp++; if (!ok) begin err++; $display("FAIL rmid_count got=%0d want=3", obs_n - b); end
    cmp++; if (obs_d[b] !== 32'h2 || obs_l[b] !== 1'b0 || obs_l[b+1] !== 1'b0 ||
               obs_d[b+2] !== 32'h22 || obs_l[b+2] !== 1'b1) begin
      err++; $display("FAIL rmid_frame got=%h/%b %h/%b want=00000002/0 00000022/1", obs_d[b], obs_l[b], obs_d[b+2], obs_l[b+2]);
    end
    cmp++; if (done_n - d !== 1) begin err++; $display("FAIL rmid_done got=%0d want=1", done_n - d); end
  endtask

  task automatic test_max_len();
    int b, d, k, nl, bad;
    b = obs_n; d = done_n;
    push(32'hABCD_00FF);
    for (int i = 1; i < 256; i++) push(32'h1000 + i);
    k = 0;
    while (obs_n - b < 256 && k < 3000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      tick(1);
      k++;
    end
    out_ready = 1'b1;
    tick(5);
    cmp++; if (obs_n - b !== 256) begin err++; $display("FAIL max_count got=%0d want=256", obs_n - b); end
    bad = 0; nl = 0;
    for (int i = 0; i < 256; i++) begin
      if (obs_d[b+i] !== ((i == 0) ? 32'hABCD_00FF : 32'h1000 + i)) bad++;
      if (obs_l[b+i] === 1'b1) nl++;
    end
    cmp++; if (bad !== 0) begin err++; $display("FAIL max_order bad_words=%0d want=0", bad); end
    cmp++; if (nl !== 1 || obs_l[b+255] !== 1'b1) begin
      err++; $display("FAIL max_last count=%0d final=%b want=1/1", nl, obs_l[b+255]);
    end
    cmp++; if (done_n - d !== 1) begin err++; $display("FAIL max_done got=%0d want=1", done_n - d); end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    tick(2);
    test_reset();
    rst_n = 1'b1;
    tick(1);
    test_basic();
    test_zero_len();
    test_backpressure();
    test_empty();
    test_reset_mid();
    test_max_len();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/fifo_pkt_reader.md
FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

Interface
REQ-001 SHALL have parameter DSIZE, default 32: data word width, matching the FIFO read side it drains.
REQ-002 SHALL have parameter LEN_W, default 8: width of the payload-length field, held in header bits [LEN_W-1:0]; LEN_W <= DSIZE.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rdata, input, DSIZE bits: FIFO head word, show-ahead, valid whenever rempty=0.
REQ-006 SHALL have port rempty, input, 1 bit: FIFO empty flag.
REQ-007 SHALL have port rinc, output, 1 bit: FIFO pop; the word on rdata is consumed in the same cycle.
REQ-008 SHALL have port out_data, output, DSIZE bits: stream data.
REQ-009 SHALL have port out_valid, output, 1 bit: stream valid.
REQ-010 SHALL have port out_ready, input, 1 bit: stream ready from the sink.
REQ-011 SHALL have port out_last, output, 1 bit: marks the final word of a packet.
REQ-012 SHALL have port pkt_done, output, 1 bit: one-cycle pulse when a last word transfers (out_valid & out_ready & out_last).
REQ-013 SHALL have port busy, output, 1 bit: high while a packet is partially popped or the output buffer is non-empty.

Function
REQ-014 SHALL frame packets as one header word followed by L payload words, L = header[LEN_W-1:0]; the header word is forwarded unchanged.
REQ-015 SHALL run an FSM with states HDR and BODY; reset state is HDR.
REQ-016 In HDR, a pop SHALL load the remaining-count register with L; if L=0, the header word carries last=1 and the FSM stays in HDR; otherwise it moves to BODY.
REQ-017 In BODY, each pop SHALL decrement the remaining count; the pop taken at count=1 carries last=1 and returns the FSM to HDR.
REQ-018 SHALL drive rinc = !rempty && (buffer occupancy < 2); rinc SHALL never be asserted while rempty=1.
REQ-019 SHALL push each popped word, with its last bit, into a 2-entry output skid buffer in the pop cycle; out_valid rises one cycle after the pop (latency 1).
REQ-020 SHALL present the oldest buffer entry on out_data/out_last with out_valid = (occupancy != 0); an entry is removed only on out_valid & out_ready.
REQ-021 SHALL keep out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL handle a simultaneous push and pop: occupancy unchanged, order preserved, sustaining 1 word/cycle when rempty=0 and out_ready=1.
REQ-023 SHALL stop popping at occupancy 2 and resume the cycle after occupancy drops.
REQ-024 SHALL support L = 2^LEN_W-1 without wrap; the remaining counter is LEN_W bits wide.
REQ-025 SHALL ignore header bits above LEN_W-1 for framing.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously return to: FSM=HDR, remaining=0, occupancy=0, out_valid=0, out_last=0, pkt_done=0, busy=0, out_data=0, rinc=0.
REQ-027 A reset asserted mid-packet SHALL discard buffered words and partial framing; after release, the next popped word SHALL be treated as a header.

Structure
REQ-028 SHALL place FSM state encodings and the default DSIZE/LEN_W constants in a shared package, bft_pkt_pkg.
REQ-029 SHALL implement the output buffer as one sub-module, skid_buf2 (2-entry, valid/ready in and out, DSIZE+1 bits wide).

Verification
REQ-030 Header 0x00000003 plus 3 payload words, out_ready=1: 4 outputs on consecutive cycles, out_last on the 4th word only, pkt_done pulses once.
REQ-031 Header L=0 followed by header L=1 plus 1 word: out_last on the 1st and 3rd outputs; 2 pkt_done pulses.
REQ-032 10 words queued, out_ready=0 for 5 cycles: exactly 2 pops then rinc=0; out_data is held; output resumes in order when out_ready=1.
REQ-033 FIFO held empty: rinc stays 0, out_valid=0; after reset with the FIFO empty, busy=0.
REQ-034 rst_n pulsed low after 2 of 5 payload words: all outputs 0 immediately; the next word after release is parsed as a header (its L is honoured).
REQ-035 Header L=255, out_ready toggling randomly: exactly 256 words out, a single out_last on the final word, no drop or duplication.
